// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Merges the CPU instruction-fetch port and data port onto one single-ported
// wishbone-style memory port. Requests are serialised with round-robin
// priority; read data and acknowledge go back to the master that issued the
// request. Each transaction walks IDLE -> BUS -> RESP, so a zero-wait slave
// costs three cycles and every slave wait state adds one BUS cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the BUS-state watchdog.
// After TIMEOUT_CYCLES BUS cycles without mem_ack_i the granted master is
// acked with zero data and the sticky timeout_o flag is raised. Without the
// macro BUS waits indefinitely and timeout_o is tied low.
//
// Parameters
//   ADDR_W         address width of all ports
//   DATA_W         data width of all ports
//   TIMEOUT_CYCLES BUS cycles before watchdog abort (ARB_TIMEOUT_EN only)
//
// Ports
//   sys_clk, sys_rst          clock (rising edge), async active-low reset
//   instr_addr_i/stb_i/we_i   fetch request from the CPU
//   instr_data_o/ack_o        fetch response
//   data_addr_i/data_i/stb_i/we_i  load/store request from the CPU
//   data_data_o/ack_o         load/store response
//   mem_addr_o/data_o/stb_o/we_o   request to the slave
//   mem_data_i/ack_i          response from the slave
//   timeout_o                 sticky watchdog flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_stb_i,
  input  logic              instr_we_i,
  output logic [DATA_W-1:0] instr_data_o,
  output logic              instr_ack_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_data_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  output logic [DATA_W-1:0] data_data_o,
  output logic              data_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} gnt_t;

  state_t state;
  gnt_t   grant;
  gnt_t   last_grant;

  logic              pick_instr;
  logic              bus_done;
  logic              bus_abort;
  logic [DATA_W-1:0] resp_data;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
    $error("cpu_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] bus_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  // Instr wins when it is the only requester, or on contention when data
  // was served last. last_grant resets to data so instr wins first.
  always_comb begin
    pick_instr = instr_stb_i && (!data_stb_i || (last_grant == GNT_DATA));
  end

  // A real slave ack always beats the watchdog, even on the limit cycle.
  always_comb begin
    bus_abort = 1'b0;
`ifdef ARB_TIMEOUT_EN
    bus_abort = !mem_ack_i && (bus_cnt == CNT_LAST);
`endif
    bus_done  = mem_ack_i || bus_abort;
    resp_data = bus_abort ? '0 : mem_data_i;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state        <= IDLE;
      grant        <= GNT_INSTR;
      last_grant   <= GNT_DATA;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_stb_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      instr_ack_o  <= 1'b0;
      data_ack_o   <= 1'b0;
      instr_data_o <= '0;
      data_data_o  <= '0;
`ifdef ARB_TIMEOUT_EN
      bus_cnt      <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (instr_stb_i || data_stb_i) begin
            state     <= BUS;
            mem_stb_o <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            bus_cnt   <= '0;
`endif
            if (pick_instr) begin
              grant      <= GNT_INSTR;
              mem_addr_o <= instr_addr_i;
              mem_data_o <= '0;
              mem_we_o   <= instr_we_i;
            end else begin
              grant      <= GNT_DATA;
              mem_addr_o <= data_addr_i;
              mem_data_o <= data_data_i;
              mem_we_o   <= data_we_i;
            end
          end
        end

        BUS: begin
          if (bus_done) begin
            state      <= RESP;
            mem_stb_o  <= 1'b0;
            last_grant <= grant;
            if (grant == GNT_INSTR) begin
              instr_ack_o  <= 1'b1;
              instr_data_o <= resp_data;
            end else begin
              data_ack_o <= 1'b1;
              // Stores return nothing useful; keep the last load value.
              if (!mem_we_o) begin
                data_data_o <= resp_data;
              end
            end
`ifdef ARB_TIMEOUT_EN
            if (bus_abort) begin
              timeout_o <= 1'b1;
            end
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          instr_ack_o <= 1'b0;
          data_ack_o  <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_stb_i = 1'b0;
  logic        instr_we_i = 1'b0;
  logic [31:0] instr_data_o;
  logic        instr_ack_o;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_data_i = '0;
  logic        data_stb_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_data_o;
  logic        data_ack_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        timeout_o;

  int vec  = 0;
  int miss = 0;

  // Slave model: acks after slv_wait BUS cycles, returns slv_rdata ^ address.
  logic        slv_en = 1'b1;
  logic        slv_force = 1'b0;
  int          slv_wait = 0;
  int          slv_cnt;
  logic [31:0] slv_rdata = '0;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)                     slv_cnt <= 0;
    else if (!mem_stb_o || mem_ack_i) slv_cnt <= 0;
    else                              slv_cnt <= slv_cnt + 1;
  end

  assign mem_ack_i  = slv_force || (slv_en && mem_stb_o && (slv_cnt == slv_wait));
  assign mem_data_i = slv_rdata ^ mem_addr_o;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .instr_addr_i(instr_addr_i), .instr_stb_i(instr_stb_i), .instr_we_i(instr_we_i),
    .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o),
    .data_addr_i(data_addr_i), .data_data_i(data_data_i), .data_stb_i(data_stb_i),
    .data_we_i(data_we_i), .data_data_o(data_data_o), .data_ack_o(data_ack_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_stb_o(mem_stb_o),
    .mem_we_o(mem_we_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .timeout_o(timeout_o)
  );

  task automatic do_reset();
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
  endtask

  // Waits (bounded) for an instr ack; returns the number of negedges waited.
  task automatic wait_instr_ack(input int bound, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < bound) begin
      @(negedge sys_clk);
      cycles++;
      if (instr_ack_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    instr_stb_i = 1'b1; instr_addr_i = 32'hFFFF_0000;
    data_stb_i = 1'b1; data_we_i = 1'b1; data_data_i = 32'hDEAD_BEEF;
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    vec++;
    if ({instr_ack_o, data_ack_o, mem_stb_o, mem_we_o, timeout_o} !== 5'b0) begin
      miss++;
      $display("FAIL reset_ctrl: got %b, want 00000",
               {instr_ack_o, data_ack_o, mem_stb_o, mem_we_o, timeout_o});
    end
    vec++;
    if ({mem_addr_o, mem_data_o, instr_data_o, data_data_o} !== 128'b0) begin
      miss++;
      $display("FAIL reset_data: addr %h wdata %h idata %h ddata %h, want all 0",
               mem_addr_o, mem_data_o, instr_data_o, data_data_o);
    end
    instr_stb_i = 1'b0; data_stb_i = 1'b0; data_we_i = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    vec++;
    if (mem_stb_o !== 1'b0) begin
      miss++;
      $display("FAIL reset_idle: mem_stb_o %b, want 0", mem_stb_o);
    end
  endtask

  task automatic test_fetch();
    slv_wait = 0; slv_rdata = 32'hA5A5_0101;
    instr_addr_i = 32'h100; instr_we_i = 1'b0; instr_stb_i = 1'b1;
    @(negedge sys_clk);
    vec++;
    if ({mem_stb_o, mem_we_o, instr_ack_o} !== 3'b100 || mem_addr_o !== 32'h100) begin
      miss++;
      $display("FAIL fetch_bus: stb/we/ack %b addr %h, want 100 addr 00000100",
               {mem_stb_o, mem_we_o, instr_ack_o}, mem_addr_o);
    end
    @(negedge sys_clk);
    vec++;
    if ({instr_ack_o, data_ack_o, mem_stb_o} !== 3'b100 || instr_data_o !== 32'hA5A5_0001) begin
      miss++;
      $display("FAIL fetch_ack: iack/dack/stb %b data %h, want 100 data a5a50001",
               {instr_ack_o, data_ack_o, mem_stb_o}, instr_data_o);
    end
    instr_stb_i = 1'b0;
    @(negedge sys_clk);
    vec++;
    if (instr_ack_o !== 1'b0 || instr_data_o !== 32'hA5A5_0001) begin
      miss++;
      $display("FAIL fetch_hold: ack %b data %h, want 0 data a5a50001", instr_ack_o, instr_data_o);
    end
  endtask

  task automatic test_load();
    slv_wait = 1; slv_rdata = 32'h5A5A_0000;
    data_addr_i = 32'h240; data_we_i = 1'b0; data_stb_i = 1'b1;
    repeat (2) begin
      @(negedge sys_clk);
      vec++;
      if ({mem_stb_o, data_ack_o} !== 2'b10) begin
        miss++;
        $display("FAIL load_wait: stb/ack %b, want 10", {mem_stb_o, data_ack_o});
      end
    end
    @(negedge sys_clk);
    vec++;
    if ({data_ack_o, instr_ack_o} !== 2'b10 || data_data_o !== 32'h5A5A_0240
        || instr_data_o !== 32'hA5A5_0001) begin
      miss++;
      $display("FAIL load_ack: dack/iack %b ddata %h idata %h, want 10 5a5a0240 a5a50001",
               {data_ack_o, instr_ack_o}, data_data_o, instr_data_o);
    end
    data_stb_i = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_store_wait();
    slv_wait = 2; slv_rdata = 32'hDEAD_0000;
    data_addr_i = 32'h200; data_data_i = 32'h1234; data_we_i = 1'b1; data_stb_i = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      vec++;
      if ({mem_stb_o, mem_we_o, data_ack_o} !== 3'b110 || mem_data_o !== 32'h1234
          || mem_addr_o !== 32'h200) begin
        miss++;
        $display("FAIL store_bus: stb/we/ack %b wdata %h addr %h, want 110 00001234 00000200",
                 {mem_stb_o, mem_we_o, data_ack_o}, mem_data_o, mem_addr_o);
      end
    end
    @(negedge sys_clk);
    vec++;
    if ({data_ack_o, mem_stb_o} !== 2'b10 || data_data_o !== 32'h5A5A_0240) begin
      miss++;
      $display("FAIL store_ack: ack/stb %b ddata %h, want 10 5a5a0240",
               {data_ack_o, mem_stb_o}, data_data_o);
    end
    data_stb_i = 1'b0; data_we_i = 1'b0;
    @(negedge sys_clk);
    vec++;
    if (data_ack_o !== 1'b0) begin
      miss++;
      $display("FAIL store_single_ack: ack %b, want 0", data_ack_o);
    end
  endtask

  task automatic test_contention();
    int acks;
    do_reset();
    slv_wait = 0; slv_rdata = 32'h1111_0000;
    instr_addr_i = 32'h300; data_addr_i = 32'h400; data_we_i = 1'b0;
    instr_stb_i = 1'b1; data_stb_i = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks < 4; c++) begin
      @(negedge sys_clk);
      vec++;
      if (instr_ack_o && data_ack_o) begin
        miss++;
        $display("FAIL contend_dual_ack: cycle %0d both acks high, want at most one", c);
      end
      if (instr_ack_o || data_ack_o) begin
        vec++;
        // Expected order: instr, data, instr, data.
        if (instr_ack_o !== ((acks % 2) == 0)) begin
          miss++;
          $display("FAIL contend_order: grant #%0d went to %s, want %s", acks,
                   instr_ack_o ? "instr" : "data", ((acks % 2) == 0) ? "instr" : "data");
        end
        vec++;
        if (instr_ack_o && instr_data_o !== 32'h1111_0300) begin
          miss++;
          $display("FAIL contend_idata: got %h, want 11110300", instr_data_o);
        end else if (data_ack_o && data_data_o !== 32'h1111_0400) begin
          miss++;
          $display("FAIL contend_ddata: got %h, want 11110400", data_data_o);
        end
        acks++;
      end
    end
    vec++;
    if (acks != 4) begin
      miss++;
      $display("FAIL contend_count: got %0d acks, want 4", acks);
    end
    instr_stb_i = 1'b0; data_stb_i = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_stray_ack();
    slv_force = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      vec++;
      if ({instr_ack_o, data_ack_o, mem_stb_o} !== 3'b000) begin
        miss++;
        $display("FAIL stray_ack: iack/dack/stb %b, want 000", {instr_ack_o, data_ack_o, mem_stb_o});
      end
    end
    slv_force = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    int  cyc;
    bit  seen;
    slv_wait = 5; slv_rdata = 32'h3333_0000;
    instr_addr_i = 32'h600; instr_stb_i = 1'b1;
    repeat (2) @(negedge sys_clk);
    vec++;
    if (mem_stb_o !== 1'b1) begin
      miss++;
      $display("FAIL midrst_pre: mem_stb_o %b, want 1", mem_stb_o);
    end
    #2 sys_rst = 1'b0;
    @(negedge sys_clk);
    vec++;
    if ({instr_ack_o, data_ack_o, mem_stb_o, mem_we_o, timeout_o} !== 5'b0
        || {mem_addr_o, mem_data_o, instr_data_o, data_data_o} !== 128'b0) begin
      miss++;
      $display("FAIL midrst_vals: ctrl %b addr %h idata %h, want 00000 0 0",
               {instr_ack_o, data_ack_o, mem_stb_o, mem_we_o, timeout_o}, mem_addr_o, instr_data_o);
    end
    instr_addr_i = 32'h700; slv_wait = 0; slv_rdata = 32'h2222_0000;
    sys_rst = 1'b1;
    wait_instr_ack(10, cyc, seen);
    vec++;
    if (!seen || cyc != 2 || instr_data_o !== 32'h2222_0700) begin
      miss++;
      $display("FAIL midrst_refetch: seen %0d after %0d cycles data %h, want 1 after 2 data 22220700",
               seen, cyc, instr_data_o);
    end
    instr_stb_i = 1'b0;
    @(negedge sys_clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  cyc;
    bit  seen;
    do_reset();
    slv_en = 1'b0; slv_rdata = 32'h4444_0000;
    instr_addr_i = 32'h800; instr_stb_i = 1'b1;
    wait_instr_ack(30, cyc, seen);
    vec++;
    // 8 BUS cycles, then the ack appears in RESP.
    if (!seen || cyc != 9 || instr_data_o !== 32'h0 || timeout_o !== 1'b1) begin
      miss++;
      $display("FAIL timeout_abort: seen %0d after %0d data %h flag %b, want 1 after 9 data 0 flag 1",
               seen, cyc, instr_data_o, timeout_o);
    end
    instr_stb_i = 1'b0; slv_en = 1'b1; slv_wait = 0;
    @(negedge sys_clk);
    instr_addr_i = 32'h900; instr_stb_i = 1'b1;
    wait_instr_ack(10, cyc, seen);
    vec++;
    if (!seen || instr_data_o !== 32'h4444_0900 || timeout_o !== 1'b1) begin
      miss++;
      $display("FAIL timeout_sticky: seen %0d data %h flag %b, want 1 44440900 1",
               seen, instr_data_o, timeout_o);
    end
    instr_stb_i = 1'b0;
    @(negedge sys_clk);
  endtask
`else
  task automatic test_timeout();
    vec++;
    if (timeout_o !== 1'b0) begin
      miss++;
      $display("FAIL timeout_tied: got %b, want 0", timeout_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store_wait();
    test_stray_ack();
    test_contention();
    test_reset_mid_bus();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
